// File: rtl/collision_scan_ctrl_if.sv
// Bundle between the obstacle generator / shared collision detector and the
// scan controller. Port suffixes are from the controller's point of view.
interface collision_scan_ctrl_if #(
    parameter int NUM_CACTI = 3
);
    logic                   frame_tick_i;
    logic                   clear_i;
    logic [NUM_CACTI-1:0]   cactus_valid_i;
    logic [9*NUM_CACTI-1:0] cactus_x_i;
    logic [9*NUM_CACTI-1:0] cactus_y_i;
    logic [6*NUM_CACTI-1:0] cactus_h_i;
    logic                   det_hit_i;
    logic [8:0]             sel_cactusX_o;
    logic [8:0]             sel_cactusY_o;
    logic [5:0]             sel_cactusHeight_o;
    logic                   scan_busy_o;
    logic                   scan_done_o;
    logic [NUM_CACTI-1:0]   hit_mask_o;
    logic                   collision_o;
    logic                   frame_overrun_o;

    modport master (
        output frame_tick_i, clear_i, cactus_valid_i, cactus_x_i, cactus_y_i,
               cactus_h_i, det_hit_i,
        input  sel_cactusX_o, sel_cactusY_o, sel_cactusHeight_o, scan_busy_o,
               scan_done_o, hit_mask_o, collision_o, frame_overrun_o
    );

    modport slave (
        input  frame_tick_i, clear_i, cactus_valid_i, cactus_x_i, cactus_y_i,
               cactus_h_i, det_hit_i,
        output sel_cactusX_o, sel_cactusY_o, sel_cactusHeight_o, scan_busy_o,
               scan_done_o, hit_mask_o, collision_o, frame_overrun_o
    );
endinterface

// File: rtl/collision_scan_ctrl.sv
// Shares one collision detector across NUM_CACTI obstacle slots: snapshots the
// slots on frame_tick, scans valid ones in turn and keeps a sticky game-over flag.
module collision_scan_ctrl #(
    parameter int NUM_CACTI   = 3,
    parameter int DET_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    collision_scan_ctrl_if.slave  bus
);
    localparam int XW = 9;
    localparam int HW = 6;
    localparam int IW = (NUM_CACTI > 1) ? $clog2(NUM_CACTI) : 1;
    localparam int CW = (DET_LATENCY > 1) ? $clog2(DET_LATENCY) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CACTI - 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(DET_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic [NUM_CACTI-1:0]    snap_valid_q;
    logic [XW*NUM_CACTI-1:0] snap_x_q;
    logic [XW*NUM_CACTI-1:0] snap_y_q;
    logic [HW*NUM_CACTI-1:0] snap_h_q;
    logic [NUM_CACTI-1:0]    scratch_q;
    logic [NUM_CACTI-1:0]    hit_mask_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    collision_q;
    logic                    overrun_q;

    logic [XW-1:0]           sel_x_s;
    logic [XW-1:0]           sel_y_s;
    logic [HW-1:0]           sel_h_s;

    // Detector operand mux; an unoccupied slot presents zeros so the detector never sees stale data.
    always_comb begin
        sel_x_s = '0;
        sel_y_s = '0;
        sel_h_s = '0;
        if ((state_q == ST_DRIVE || state_q == ST_WAIT) && snap_valid_q[idx_q]) begin
            sel_x_s = snap_x_q[XW*int'(idx_q) +: XW];
            sel_y_s = snap_y_q[XW*int'(idx_q) +: XW];
            sel_h_s = snap_h_q[HW*int'(idx_q) +: HW];
        end else begin
            sel_x_s = '0;
            sel_y_s = '0;
            sel_h_s = '0;
        end
    end

    // Scan sequencer: snapshot, per-slot drive/wait, and sticky result flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            snap_valid_q <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_h_q     <= '0;
            scratch_q    <= '0;
            hit_mask_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            collision_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (bus.clear_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            scratch_q    <= '0;
            hit_mask_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            collision_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.frame_tick_i && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else begin
                overrun_q <= overrun_q;
            end
            case (state_q)
                ST_IDLE: begin
                    // Once game over is latched the scene stays frozen until clear.
                    if (bus.frame_tick_i && !collision_q) begin
                        snap_valid_q <= bus.cactus_valid_i;
                        snap_x_q     <= bus.cactus_x_i;
                        snap_y_q     <= bus.cactus_y_i;
                        snap_h_q     <= bus.cactus_h_i;
                        idx_q        <= '0;
                        scratch_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_DRIVE;
                    end else begin
                        busy_q       <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (snap_valid_q[idx_q]) begin
                        cnt_q   <= WAIT_INIT;
                        state_q <= ST_WAIT;
                    end else begin
                        scratch_q[idx_q] <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_DRIVE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        scratch_q[idx_q] <= bus.det_hit_i;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_DRIVE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    hit_mask_q  <= scratch_q;
                    collision_q <= collision_q | (|scratch_q);
                    idx_q       <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_cactusX_o      = sel_x_s;
    assign bus.sel_cactusY_o      = sel_y_s;
    assign bus.sel_cactusHeight_o = sel_h_s;
    assign bus.scan_busy_o        = busy_q;
    assign bus.scan_done_o        = done_q;
    assign bus.hit_mask_o         = hit_mask_q;
    assign bus.collision_o        = collision_q;
    assign bus.frame_overrun_o    = overrun_q;
endmodule
